// File: rtl/regfile_writeback_pkg.sv
// Shared types for the register-file write-back slice.
package regfile_writeback_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       value;
    } wb_entry_t;

endpackage

// File: rtl/wb_result_fifo.sv
// Small circular buffer holding long-latency results until the write port is free.
module wb_result_fifo
    import regfile_writeback_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      push,
    input  wb_entry_t push_data,
    input  logic      pop,
    output wb_entry_t head,
    output logic      full,
    output logic      empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    wb_entry_t         mem [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [CW-1:0]     count;
    logic              do_push;
    logic              do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (do_pop && !do_push) count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/regfile_writeback.sv
// Register-file write port: ALU/LSU arbitration, pending-write scoreboard, optional operand bypass.
// Define WB_BYPASS_EN to forward the in-flight write value onto op1/op2 instead of stalling.
module regfile_writeback
    import regfile_writeback_pkg::*;
#(
    parameter int FIFO_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  alu_valid,
    input  logic [REG_ADDR_W-1:0] alu_rd,
    input  logic [XLEN-1:0]       alu_value,
    input  logic                  lsu_valid,
    output logic                  lsu_ready,
    input  logic [REG_ADDR_W-1:0] lsu_rd,
    input  logic [XLEN-1:0]       lsu_value,
    input  logic                  issue_long,
    input  logic [REG_ADDR_W-1:0] issue_rd,
    input  logic [REG_ADDR_W-1:0] src1_num,
    input  logic [REG_ADDR_W-1:0] src2_num,
    input  logic [XLEN-1:0]       regdata1,
    input  logic [XLEN-1:0]       regdata2,
    output logic                  src1_busy,
    output logic                  src2_busy,
    output logic [XLEN-1:0]       op1,
    output logic [XLEN-1:0]       op2,
    output logic [REG_ADDR_W-1:0] dstreg_num,
    output logic [XLEN-1:0]       write_value,
    output logic                  reg_we
);

    wb_entry_t   fifo_head;
    wb_entry_t   winner;
    logic        fifo_full;
    logic        fifo_empty;
    logic        fifo_pop;
    logic        win_valid;
    logic [31:0] pending;
    logic        match1;
    logic        match2;
    logic        haz1;
    logic        haz2;

    wb_result_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (lsu_valid),
        .push_data ('{rd: lsu_rd, value: lsu_value}),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign lsu_ready = !fifo_full;

    // Strict ALU priority: the buffer only drains on ALU-idle cycles.
    assign fifo_pop  = !alu_valid && !fifo_empty;
    assign win_valid = alu_valid || !fifo_empty;
    assign winner    = alu_valid ? '{rd: alu_rd, value: alu_value} : fifo_head;

    always_ff @(posedge clk) begin
        if (rst) begin
            reg_we      <= 1'b0;
            dstreg_num  <= ZERO_REG;
            write_value <= '0;
            pending     <= '0;
        end else begin
            reg_we <= win_valid && (winner.rd != ZERO_REG);
            if (win_valid) begin
                dstreg_num  <= winner.rd;
                write_value <= winner.value;
            end
            // Set after clear so a same-register reissue stays pending.
            for (int r = 1; r < 32; r++) begin
                if (fifo_pop && fifo_head.rd == REG_ADDR_W'(r)) pending[r] <= 1'b0;
                if (issue_long && issue_rd == REG_ADDR_W'(r))  pending[r] <= 1'b1;
            end
        end
    end

    assign match1 = reg_we && (dstreg_num == src1_num) && (src1_num != ZERO_REG);
    assign match2 = reg_we && (dstreg_num == src2_num) && (src2_num != ZERO_REG);

`ifdef WB_BYPASS_EN
    assign haz1 = 1'b0;
    assign haz2 = 1'b0;
    assign op1  = match1 ? write_value : regdata1;
    assign op2  = match2 ? write_value : regdata2;
`else
    assign haz1 = match1;
    assign haz2 = match2;
    assign op1  = regdata1;
    assign op2  = regdata2;
`endif

    assign src1_busy = pending[src1_num] | haz1;
    assign src2_busy = pending[src2_num] | haz2;

endmodule

// File: tb/tb_regfile_writeback.sv
// Directed bench for regfile_writeback; expectations follow WB_BYPASS_EN when defined.
module tb_regfile_writeback;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid, lsu_valid, issue_long;
    logic [4:0]  alu_rd, lsu_rd, issue_rd, src1_num, src2_num;
    logic [31:0] alu_value, lsu_value, regdata1, regdata2;
    logic        lsu_ready, src1_busy, src2_busy, reg_we;
    logic [31:0] op1, op2, write_value;
    logic [4:0]  dstreg_num;

    int vectors = 0;
    int errors  = 0;

`ifdef WB_BYPASS_EN
    localparam logic BYP = 1'b1;
`else
    localparam logic BYP = 1'b0;
`endif

    regfile_writeback #(.FIFO_DEPTH(2)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_value(alu_value),
        .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_value(lsu_value),
        .issue_long(issue_long), .issue_rd(issue_rd),
        .src1_num(src1_num), .src2_num(src2_num), .regdata1(regdata1), .regdata2(regdata2),
        .src1_busy(src1_busy), .src2_busy(src2_busy), .op1(op1), .op2(op2),
        .dstreg_num(dstreg_num), .write_value(write_value), .reg_we(reg_we)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1;
        alu_valid = 0; alu_rd = 0; alu_value = 0;
        lsu_valid = 0; lsu_rd = 0; lsu_value = 0;
        issue_long = 0; issue_rd = 0;
        src1_num = 0; src2_num = 0; regdata1 = 0; regdata2 = 0;
        tick(); tick();
        rst = 1'b0;
        src1_num = 5'd9;
        #1;
        check("rst_we",    32'(reg_we), 32'd0);
        check("rst_dst",   32'(dstreg_num), 32'd0);
        check("rst_wval",  write_value, 32'd0);
        check("rst_ready", 32'(lsu_ready), 32'd1);
        check("rst_busy1", 32'(src1_busy), 32'd0);

        // ALU write to r5
        alu_valid = 1; alu_rd = 5'd5; alu_value = 32'h1234;
        tick();
        alu_valid = 0;
        src1_num = 5'd5; regdata1 = 32'h55;
        #1;
        check("alu_we",    32'(reg_we), 32'd1);
        check("alu_dst",   32'(dstreg_num), 32'd5);
        check("alu_wval",  write_value, 32'h1234);
        check("alu_haz",   32'(src1_busy), BYP ? 32'd0 : 32'd1);
        check("alu_op1",   op1, BYP ? 32'h1234 : 32'h55);
        tick();
        check("idle_we",   32'(reg_we), 32'd0);
        check("idle_busy", 32'(src1_busy), 32'd0);
        check("idle_op1",  op1, 32'h55);

        // x0 is never written nor pending
        alu_valid = 1; alu_rd = 5'd0; alu_value = 32'hFFFF;
        issue_long = 1; issue_rd = 5'd0;
        tick();
        alu_valid = 0; issue_long = 0;
        src1_num = 5'd0;
        #1;
        check("x0_we",   32'(reg_we), 32'd0);
        check("x0_busy", 32'(src1_busy), 32'd0);

        // long-latency RAW on r7
        issue_long = 1; issue_rd = 5'd7;
        tick();
        issue_long = 0; src1_num = 5'd7;
        #1;
        check("raw_busy0", 32'(src1_busy), 32'd1);
        tick();
        check("raw_busy1", 32'(src1_busy), 32'd1);
        lsu_valid = 1; lsu_rd = 5'd7; lsu_value = 32'h777;
        #1;
        check("raw_ready", 32'(lsu_ready), 32'd1);
        tick();
        lsu_valid = 0;
        #1;
        check("raw_busy2", 32'(src1_busy), 32'd1);
        tick();
        check("raw_we",    32'(reg_we), 32'd1);
        check("raw_dst",   32'(dstreg_num), 32'd7);
        check("raw_wval",  write_value, 32'h777);
        check("raw_busy3", 32'(src1_busy), BYP ? 32'd0 : 32'd1);
        check("raw_op1",   op1, BYP ? 32'h777 : 32'h55);
        tick();
        check("raw_busy4", 32'(src1_busy), 32'd0);

        // FIFO fills while ALU holds the port
        alu_valid = 1; alu_rd = 5'd1; alu_value = 32'h100;
        lsu_valid = 1; lsu_rd = 5'd10; lsu_value = 32'hA;
        tick();
        lsu_rd = 5'd11; lsu_value = 32'hB;
        #1;
        check("fill_ready1", 32'(lsu_ready), 32'd1);
        tick();
        lsu_rd = 5'd12; lsu_value = 32'hC;
        #1;
        check("fill_ready2", 32'(lsu_ready), 32'd0);
        tick();
        check("fill_ready3", 32'(lsu_ready), 32'd0);
        check("fill_dst",    32'(dstreg_num), 32'd1);
        check("fill_wval",   write_value, 32'h100);
        alu_valid = 0; lsu_valid = 0;
        tick();
        check("drain0_dst",  32'(dstreg_num), 32'd10);
        check("drain0_wval", write_value, 32'hA);
        check("drain0_rdy",  32'(lsu_ready), 32'd1);
        tick();
        check("drain1_we",   32'(reg_we), 32'd1);
        check("drain1_dst",  32'(dstreg_num), 32'd11);
        check("drain1_wval", write_value, 32'hB);
        tick();
        check("drain2_we",   32'(reg_we), 32'd0);

        // operand 2 in flight
        alu_valid = 1; alu_rd = 5'd3; alu_value = 32'hAA;
        tick();
        alu_valid = 0; src2_num = 5'd3; regdata2 = 32'h0;
        #1;
        check("byp_op2",  op2, BYP ? 32'hAA : 32'h0);
        check("byp_busy", 32'(src2_busy), BYP ? 32'd0 : 32'd1);
        tick();

        // reset with full FIFO and pending r9
        issue_long = 1; issue_rd = 5'd9;
        alu_valid = 1; alu_rd = 5'd2; alu_value = 32'h22;
        lsu_valid = 1; lsu_rd = 5'd13; lsu_value = 32'hD;
        tick();
        issue_long = 0; lsu_rd = 5'd14; lsu_value = 32'hE;
        tick();
        lsu_valid = 0; src1_num = 5'd9;
        #1;
        check("pre_rst_rdy",  32'(lsu_ready), 32'd0);
        check("pre_rst_busy", 32'(src1_busy), 32'd1);
        rst = 1; alu_valid = 0;
        tick();
        rst = 0;
        #1;
        check("mid_rst_we",   32'(reg_we), 32'd0);
        check("mid_rst_rdy",  32'(lsu_ready), 32'd1);
        check("mid_rst_busy", 32'(src1_busy), 32'd0);
        tick();
        check("post_rst_we",  32'(reg_we), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
